mux_ent_tx_sequencer: RTL and testbench

//  Sequences the 13-channel byte mux feeding the RTC bus-cycle block. On start it

---
 rtl/mux_ent_tx_sequencer_if.sv | 27 ++
 rtl/mux_ent_tx_sequencer.sv | 138 +++++++++++++
 tb/tb_mux_ent_tx_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_ent_tx_sequencer_if.sv
// Handshake bundle between the RTC control FSM / bus-cycle block (master side)
// and the 13-channel mux transmit sequencer (slave side).
interface mux_ent_tx_sequencer_if #(
  parameter int SEL_W = 4
);
  logic             start;
  logic [SEL_W-1:0] len;
  logic             abort;
  logic             bus_ack;
  logic [SEL_W-1:0] sel;
  logic             r_s;
  logic             bus_req;
  logic             first;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, len, abort, bus_ack,
    input  sel, r_s, bus_req, first, busy, done, err
  );

  modport slave (
    input  start, len, abort, bus_ack,
    output sel, r_s, bus_req, first, busy, done, err
  );
endinterface

// File: rtl/mux_ent_tx_sequencer.sv
// Steps the byte-mux select from channel 0 to a captured last channel and
// issues one req/ack handshake per byte to the RTC bus-cycle block, with a
// per-byte ack timeout. All outputs come straight from flops.
module mux_ent_tx_sequencer #(
  parameter int NUM_CH  = 13,
  parameter int SEL_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  mux_ent_tx_sequencer_if.slave io
);

  localparam int               TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [SEL_W-1:0] LAST_MAX = SEL_W'(NUM_CH - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_REQ,
    S_NEXT,
    S_DONE,
    S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [TMR_W-1:0]   timer_q, timer_d;

  logic               r_s_q, r_s_d;
  logic               bus_req_q, bus_req_d;
  logic               first_q, first_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    timer_d = timer_q;

    if (io.abort && (state_q != S_IDLE)) begin
      // Abort outranks ack and timeout; sel keeps its current value.
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (io.start) begin
            state_d = S_SETUP;
            idx_d   = '0;
            last_d  = (io.len > LAST_MAX) ? LAST_MAX : io.len;
          end
        end
        S_SETUP: begin
          // One settle cycle for the mux output; the ack timer restarts here.
          state_d = S_REQ;
          timer_d = '0;
        end
        S_REQ: begin
          // Ack is tested first so it wins over a timeout in the same cycle.
          if (io.bus_ack) begin
            state_d = S_NEXT;
          end else if (timer_q == TMR_MAX) begin
            state_d = S_ERR;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_NEXT: begin
          if (idx_q == last_q) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_SETUP;
          end
        end
        S_DONE:  state_d = S_IDLE;
        S_ERR:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are decoded from the next state so the flops line up with it.
    busy_d    = (state_d != S_IDLE);
    r_s_d     = (state_d inside {S_SETUP, S_REQ, S_NEXT});
    bus_req_d = (state_d == S_REQ);
    done_d    = (state_d == S_DONE);
    err_d     = (state_d == S_ERR);
    // first marks byte 0 only while a byte is actually presented, so it stays
    // low in IDLE even though sel may rest at 0.
    first_d   = r_s_d && (idx_d == '0);
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge only (not in the sensitivity
    // list), and all state uses non-blocking assignment so every flop sees
    // the pre-edge values of the others.
    if (!reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      last_q    <= '0;
      timer_q   <= '0;
      r_s_q     <= 1'b0;
      bus_req_q <= 1'b0;
      first_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      timer_q   <= timer_d;
      r_s_q     <= r_s_d;
      bus_req_q <= bus_req_d;
      first_q   <= first_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign io.sel     = idx_q;
  assign io.r_s     = r_s_q;
  assign io.bus_req = bus_req_q;
  assign io.first   = first_q;
  assign io.busy    = busy_q;
  assign io.done    = done_q;
  assign io.err     = err_q;

endmodule

// File: tb/tb_mux_ent_tx_sequencer.sv
// Scoreboard bench for mux_ent_tx_sequencer: stimulus pushes the expected
// bus_req / done / err events, a negedge monitor pops and compares them.
module tb_mux_ent_tx_sequencer;

  localparam int LAST_MAX = 12;
  localparam int TIMEOUT  = 255;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mux_ent_tx_sequencer_if #(.SEL_W(4)) bus ();

  mux_ent_tx_sequencer #(
    .NUM_CH (13),
    .SEL_W  (4),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .io   (bus)
  );

  logic auto_ack = 1'b0;
  logic man_ack  = 1'b0;
  assign bus.bus_ack = auto_ack | man_ack;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // kind: 1 = bus_req rise, 2 = done, 3 = err
  typedef struct {
    int kind;
    int cyc;
    int sel;
    int first;
    int r_s;
    int busy;
  } ev_t;

  ev_t exp_q[$];
  ev_t e;
  int  req_seen  = 0;
  int  ack_delay = 0;
  int  stall_sel = -1;
  int  rc        = 0;
  int  kind      = 0;
  logic prev_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus-cycle responder: acks ack_delay cycles into REQ, never for stall_sel.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.bus_req === 1'b1) begin
        auto_ack = (rc == ack_delay) && (int'(bus.sel) != stall_sel);
        rc++;
      end else begin
        auto_ack = 1'b0;
        rc       = 0;
      end
    end
  end

  // Monitor: compares every presented event against the scoreboard queue.
  initial begin
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        prev_req = 1'b0;
      end else begin
        kind = 0;
        if (bus.err === 1'b1) kind = 3;
        if (bus.done === 1'b1) kind = 2;
        if ((bus.bus_req === 1'b1) && !prev_req) kind = 1;
        prev_req = (bus.bus_req === 1'b1);
        if ((bus.done === 1'b1) && (bus.err === 1'b1)) check("done_err_exclusive", 1, 0);
        if (kind != 0) begin
          if (kind == 1) req_seen++;
          if (exp_q.size() == 0) begin
            check("unexpected_event_kind", kind, 0);
          end else begin
            e = exp_q.pop_front();
            check("ev_kind",  kind,      e.kind);
            check("ev_cycle", cyc,       e.cyc);
            check("ev_sel",   bus.sel,   e.sel);
            check("ev_first", bus.first, e.first);
            check("ev_r_s",   bus.r_s,   e.r_s);
            check("ev_busy",  bus.busy,  e.busy);
          end
        end
      end
    end
  end

  // Expected events for a run started in cycle c0. Byte i's REQ begins at t,
  // its ack lands at t+delay, NEXT at t+delay+1, next REQ at t+delay+3.
  // stall: byte that never gets an ack; cut: last byte before an abort.
  task automatic expect_run(input int c0, input int l, input int delay,
                            input int stall, input int cut);
    int last = (l > LAST_MAX) ? LAST_MAX : l;
    int t    = c0 + 2;
    for (int i = 0; i <= last; i++) begin
      exp_q.push_back('{1, t, i, (i == 0) ? 1 : 0, 1, 1});
      if (i == cut) return;
      if (i == stall) begin
        exp_q.push_back('{3, t + TIMEOUT + 1, i, 0, 0, 1});
        return;
      end
      if (i == last) exp_q.push_back('{2, t + delay + 2, i, 0, 0, 1});
      t += delay + 3;
    end
  endtask

  task automatic pulse_start(input int l, output int c0);
    @(posedge clk); #1;
    c0        = cyc;
    bus.len   = 4'(l);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run(input int l, input int delay, input int stall,
                     input int cut, output int c0);
    ack_delay = delay;
    stall_sel = stall;
    pulse_start(l, c0);
    expect_run(c0, l, delay, stall, cut);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((bus.busy === 1'b1) && (n < budget)) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_within_budget", bus.busy, 0);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},    bus.busy,    0);
    check({tag, "_bus_req"}, bus.bus_req, 0);
    check({tag, "_r_s"},     bus.r_s,     0);
    check({tag, "_done"},    bus.done,    0);
    check({tag, "_err"},     bus.err,     0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    int r0;

    // Reset held with start asserted: nothing may move.
    bus.start = 1'b1;
    bus.len   = 4'd12;
    bus.abort = 1'b0;
    reset     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sel",   bus.sel,   0);
    check("rst_first", bus.first, 0);
    check_quiet("rst");
    bus.start = 1'b0;
    reset     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("post_rst");

    // Full 13-byte run, ack in first REQ cycle: done at 40, busy falls at 41.
    r0 = req_seen;
    run(12, 0, -1, -1, c0);
    wait_idle(100);
    check("full_busy_fall", cyc, c0 + 41);
    check("full_req_count", req_seen - r0, 13);
    check("full_sel_hold",  bus.sel, 12);

    // Clamp: len=15 behaves like len=12.
    run(15, 0, -1, -1, c0);
    wait_idle(100);
    check("clamp_busy_fall", cyc, c0 + 41);
    check("clamp_sel_hold",  bus.sel, 12);

    // Single byte: done at cycle 4.
    run(0, 0, -1, -1, c0);
    wait_idle(20);
    check("single_busy_fall", cyc, c0 + 5);

    // Timeout on byte 1, then a clean restart from sel=0.
    run(3, 0, 1, -1, c0);
    wait_idle(400);
    check("timeout_busy_fall", cyc, c0 + 262);
    run(3, 0, -1, -1, c0);
    wait_idle(40);
    check("restart_busy_fall", cyc, c0 + 14);

    // Abort in the first REQ cycle of byte 2 (ack would come later).
    run(5, 3, -1, 2, c0);
    wait_until(c0 + 14);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check("abort_cycle", cyc, c0 + 15);
    check_quiet("abort");
    repeat (6) @(posedge clk);
    #1;
    check_quiet("abort_after");

    // Abort in the same cycle as bus_ack: abort wins.
    run(5, 0, -1, 2, c0);
    wait_until(c0 + 8);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check_quiet("abort_ack");
    repeat (4) @(posedge clk);
    #1;
    check_quiet("abort_ack_after");

    // start while busy is ignored.
    run(2, 0, -1, -1, c0);
    wait_until(c0 + 2);
    bus.len   = 4'd12;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle(40);
    check("busy_start_fall", cyc, c0 + 11);
    repeat (3) @(posedge clk);
    #1;
    check_quiet("busy_start_after");

    // bus_ack during SETUP is ignored; real ack arrives 2 cycles into REQ.
    run(0, 2, -1, -1, c0);
    man_ack = 1'b1;
    @(posedge clk); #1;
    man_ack = 1'b0;
    wait_idle(20);
    check("setup_ack_fall", cyc, c0 + 7);

    // Ack exactly on the timer==TIMEOUT cycle: NEXT, not ERR.
    run(0, TIMEOUT, -1, -1, c0);
    wait_idle(400);
    check("late_ack_fall", cyc, c0 + 260);

    // Reset during SETUP overrides the transfer.
    pulse_start(12, c0);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("midrst_sel", bus.sel, 0);
    check_quiet("midrst");
    repeat (4) @(posedge clk);
    #1;
    check_quiet("midrst_after");

    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
